urecip_inverse_seq_8bit_frac_to_8bit_int: RTL and testbench
===========================================================

URECIP_INVERSE_SEQ_8BIT_FRAC_TO_8BIT_INT -- requirements
Module: urecip_inverse_seq_8bit_frac_to_8bit_int

Interface
REQ-001 SHALL have parameter ZERO_RESULT, default 8'd255: the result returned for a zero fraction input.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 SHALL have port frac_in, input, 8 bits: unsigned Q0.8 reciprocal value f, meaning f/256.
REQ-005 SHALL have port in_valid, input, 1 bit: frac_in is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an operand.
REQ-007 SHALL have port number_out, output, 8 bits: the recovered unsigned integer n.
REQ-008 SHALL have port div_by_zero, output, 1 bit: number_out came from f == 0; qualified by out_valid.
REQ-009 SHALL have port out_valid, output, 1 bit: number_out and div_by_zero are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.

Function
REQ-011 SHALL compute number_out = floor(256/f) - 1 for f in 1..255, the inverse of the 8-bit reciprocal table (n -> floor(256/(n+1))), with f=0x80 -> 1, 0x55 -> 2, 0x40 -> 3, 0x33 -> 4, 0xFF -> 0 and 0x01 -> 255.
REQ-012 SHALL implement the arithmetic as restoring division:
  - 9-bit dividend constant 9'h100 and 8-bit divisor f.
  - 9-bit partial remainder and 9-bit quotient.
  - One quotient bit per cycle, MSB first.
REQ-013 SHALL clamp the final quotient minus one to 8 bits; the quotient max is 256 and its min is 1, so no underflow occurs.
REQ-014 SHALL use a state machine with states IDLE, DIVIDE and DONE.
REQ-015 SHALL drive in_ready high only in IDLE.
REQ-016 SHALL accept an operand on a clock edge where in_valid && in_ready, registering frac_in.
REQ-017 SHALL, on accepting f != 0, go from IDLE to DIVIDE and run exactly 9 iterations with a 4-bit counter.
REQ-018 SHALL go from DIVIDE to DONE on the edge that completes iteration 9.
REQ-019 SHALL, for f != 0, assert out_valid 10 cycles after the accepting edge.
REQ-020 SHALL, for f == 0, skip DIVIDE and go IDLE -> DONE, with out_valid 1 cycle after acceptance, number_out = ZERO_RESULT and div_by_zero = 1.
REQ-021 SHALL drive div_by_zero to 0 for every nonzero f.
REQ-022 SHALL assert out_valid only in DONE.
REQ-023 SHALL hold number_out and div_by_zero stable while out_valid && !out_ready (backpressure, for any number of cycles).
REQ-024 SHALL return from DONE to IDLE on the edge where out_valid && out_ready.
REQ-025 SHALL keep in_ready low in that handoff cycle, so there is no same-cycle re-accept; the next accept is possible at the earliest one cycle later.
REQ-026 SHALL ignore in_valid and frac_in outside IDLE; an operand changing during DIVIDE does not affect the result in progress.
REQ-027 SHALL keep throughput at one result per 11 cycles minimum for nonzero f with out_ready held high.
REQ-028 SHALL keep number_out registered, with no combinational path from frac_in or out_ready to any output.

Reset
REQ-029 SHALL, with rst high at a rising edge, force state IDLE, in_ready = 1, out_valid = 0, number_out = 0, div_by_zero = 0, the iteration counter to 0, and the partial remainder and quotient to 0.
REQ-030 SHALL let rst take priority over all other inputs, including mid-DIVIDE and in DONE under backpressure; the in-flight operation is discarded and no out_valid results from it.
REQ-031 SHALL accept a new operand on the first edge after rst deasserts if in_valid is high.

Verification
REQ-032 Exhaustive sweep: f = 0..255 with out_ready = 1 -> each number_out equals floor(256/f) - 1 (255 for f = 0), and re-applying the reciprocal table to number_out returns f for every f in that table's output set.
REQ-033 Latency: accept f = 0x55 at edge k -> out_valid high first at edge k+10 with number_out = 2 and div_by_zero = 0; accept f = 0x00 at edge k -> out_valid at k+1 with number_out = 255 and div_by_zero = 1.
REQ-034 Backpressure: f = 0x33 with out_ready low for 5 cycles after out_valid -> number_out holds 4, in_ready stays 0, and after one out_ready pulse the state returns to IDLE with in_ready high the next cycle.
REQ-035 Input churn: accept f = 0x40, then toggle in_valid and frac_in = 0x01 every cycle during DIVIDE -> result is 3 and the second operand is accepted only after the handoff.
REQ-036 Reset mid-operation: rst high at iteration 5 of f = 0x80 -> the next cycle shows out_valid = 0, in_ready = 1 and number_out = 0, and a subsequent f = 0x80 yields 1.
REQ-037 Back-to-back: stream 0xFF, 0x01, 0x80 with out_ready = 1 -> results 0, 255, 1 in order, with 11 cycles between consecutive accepts.

Source files
------------

// File: rtl/urecip_inverse_seq_8bit_frac_to_8bit_int.sv
// Recovers the integer n from its 8-bit Q0.8 reciprocal f = floor(256/(n+1)).
// It returns floor(256/f) - 1, computed as a sequential restoring division
// that produces one quotient bit per cycle, MSB first.
// Handshakes are valid/ready on both sides. A zero fraction skips the divider
// and returns ZERO_RESULT with div_by_zero set.
module urecip_inverse_seq_8bit_frac_to_8bit_int #(
    parameter logic [7:0] ZERO_RESULT = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] frac_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] number_out,
    output logic       div_by_zero,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    // The dividend is 256. Its nine bits are shifted into the remainder MSB first.
    localparam logic [8:0] DIVIDEND  = 9'h100;
    // Index of the ninth and final iteration.
    localparam logic [3:0] LAST_ITER = 4'd8;

    state_t      state;
    logic [7:0]  frac_q;      // divisor captured at accept
    logic [3:0]  count;       // iteration index, 0..8
    logic [8:0]  rem;         // partial remainder
    logic [8:0]  quo;         // quotient bits gathered so far

    logic [3:0]  bit_idx;
    logic        dividend_bit;
    logic [9:0]  rem_wide;
    logic [9:0]  rem_diff;
    logic        q_bit;
    logic [8:0]  rem_next;
    logic [8:0]  quo_next;
    logic [8:0]  quo_minus_one;
    logic [7:0]  result;

    // One restoring-division step, plus the final quotient-minus-one.
    always_comb begin
        // NOTE: every variable gets a default value first. A path that leaves
        // a variable unassigned would make synthesis infer a latch.
        bit_idx       = 4'd0;
        dividend_bit  = 1'b0;
        rem_wide      = 10'd0;
        rem_diff      = 10'd0;
        q_bit         = 1'b0;
        rem_next      = 9'd0;
        quo_next      = 9'd0;
        quo_minus_one = 9'd0;
        result        = 8'd0;

        bit_idx      = LAST_ITER - count;
        dividend_bit = DIVIDEND[bit_idx];

        // Shift in the next dividend bit, then do a trial subtraction.
        // Bit 9 of the difference is set when the shifted remainder is
        // smaller than f. In that case the quotient bit is 0 and the
        // remainder is restored.
        rem_wide = {rem, dividend_bit};
        rem_diff = rem_wide - {2'b00, frac_q};
        q_bit    = ~rem_diff[9];
        rem_next = q_bit ? rem_diff[8:0] : rem_wide[8:0];
        quo_next = (quo << 1) | {8'd0, q_bit};

        // The quotient lies in 1..256, so subtracting one always fits 8 bits.
        // The saturation only guards an unreachable wrap.
        quo_minus_one = quo_next - 9'd1;
        result        = quo_minus_one[8] ? 8'hFF : quo_minus_one[7:0];
    end

    // Control FSM and datapath registers. Every output is a flop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // flop then samples values from before the edge, whatever the
        // statement order.
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            number_out  <= 8'd0;
            div_by_zero <= 1'b0;
            frac_q      <= 8'd0;
            count       <= 4'd0;
            rem         <= 9'd0;
            quo         <= 9'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        frac_q   <= frac_in;
                        in_ready <= 1'b0;
                        if (frac_in == 8'd0) begin
                            // A zero fraction has no reciprocal to invert,
                            // so its result is ready in one cycle.
                            state       <= DONE;
                            number_out  <= ZERO_RESULT;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                        end else begin
                            state <= DIVIDE;
                            count <= 4'd0;
                            rem   <= 9'd0;
                            quo   <= 9'd0;
                        end
                    end
                end

                DIVIDE: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    if (count == LAST_ITER) begin
                        state       <= DONE;
                        number_out  <= result;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                    end else begin
                        count <= count + 4'd1;
                    end
                end

                DONE: begin
                    // The result holds while the consumer stalls.
                    // in_ready rises only after the handoff edge.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_urecip_inverse_seq_8bit_frac_to_8bit_int.sv
// Self-checking bench for urecip_inverse_seq_8bit_frac_to_8bit_int.
// Each accepted operand pushes its expected result and accept edge onto a
// scoreboard. A negedge monitor pops the entry and compares it when the DUT
// hands over a result.
module tb_urecip_inverse_seq_8bit_frac_to_8bit_int;

    logic       clk;
    logic       rst;
    logic [7:0] frac_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] number_out;
    logic       div_by_zero;
    logic       out_valid;
    logic       out_ready;

    urecip_inverse_seq_8bit_frac_to_8bit_int #(
        .ZERO_RESULT(8'd255)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frac_in    (frac_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .number_out (number_out),
        .div_by_zero(div_by_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] f;
        logic [7:0] number;
        logic       dbz;
        int         acc_edge;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   acc_count   = 0;
    int   last_acc    = 0;
    int   rise_edge   = 0;
    logic prev_ov     = 1'b0;
    int   recip [256];
    bit   in_set[256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp_val);
        vectors++;
        if (got != exp_val) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp_val, $time);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] f);
        if (f == 8'd0) return 8'd255;
        return 8'((256 / int'(f)) - 1);
    endfunction

    // Scoreboard monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) rise_edge = cyc + 1;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    check("in_ready_low_in_done", int'(in_ready), 0);
                    if (out_ready) begin
                        e = sb.pop_front();
                        check($sformatf("number_f%02h", e.f), int'(number_out), int'(e.number));
                        check($sformatf("dbz_f%02h", e.f), int'(div_by_zero), int'(e.dbz));
                        check($sformatf("latency_f%02h", e.f), rise_edge - e.acc_edge,
                              (e.f == 8'd0) ? 1 : 10);
                        if (e.f != 8'd0 && in_set[e.f])
                            check($sformatf("roundtrip_f%02h", e.f), recip[number_out], int'(e.f));
                    end else begin
                        check("hold_number", int'(number_out), int'(sb[0].number));
                        check("hold_dbz", int'(div_by_zero), int'(sb[0].dbz));
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.f        = frac_in;
                e.number   = model(frac_in);
                e.dbz      = (frac_in == 8'd0);
                e.acc_edge = cyc + 1;
                sb.push_back(e);
                acc_count++;
                last_acc = cyc + 1;
            end
            prev_ov = out_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] f, output int acc_edge);
        int  n0;
        bit  got;
        n0       = acc_count;
        got      = 1'b0;
        in_valid = 1'b1;
        frac_in  = f;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (acc_count != n0) got = 1'b1;
        end
        in_valid = 1'b0;
        if (!got) check("issue_timeout", 0, 1);
        acc_edge = last_acc;
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else step();
        end
        if (!seen) check("valid_timeout", 0, 1);
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 60 && !empty; i++) begin
            if (sb.size() == 0) empty = 1'b1;
            else step();
        end
        if (!empty) check("drain_timeout", 0, 1);
        step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_number"}, int'(number_out), 0);
        check({tag, "_dbz"}, int'(div_by_zero), 0);
    endtask

    initial begin
        int e0, e1, e2, rel;

        for (int n = 0; n < 256; n++) begin
            recip[n] = 256 / (n + 1);
            in_set[recip[n]] = 1'b1;
        end

        rst       = 1'b1;
        in_valid  = 1'b0;
        frac_in   = 8'd0;
        out_ready = 1'b1;
        repeat (3) step();
        check_reset_state("reset");

        // An operand waiting while rst is high is taken on the first free edge.
        in_valid = 1'b1;
        frac_in  = 8'h55;
        rst      = 1'b0;
        rel      = cyc;
        issue(8'h55, e0);
        check("accept_after_reset", e0, rel + 1);
        drain();
        issue(8'h00, e0);
        drain();

        // Exhaustive sweep with the consumer always ready.
        for (int f = 0; f < 256; f++) issue(8'(f), e0);
        drain();

        // Backpressure: the result must hold for five stalled cycles.
        out_ready = 1'b0;
        issue(8'h33, e0);
        wait_valid();
        repeat (5) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_in_ready_after_handoff", int'(in_ready), 1);
        check("bp_out_valid_after_handoff", int'(out_valid), 0);
        out_ready = 1'b1;

        // Input churn during DIVIDE: the second operand waits for the handoff.
        issue(8'h40, e1);
        for (int i = 0; i < 40 && last_acc == e1; i++) begin
            in_valid = ~in_valid;
            frac_in  = 8'h01;
            step();
        end
        in_valid = 1'b0;
        check("churn_second_accept_after_handoff", int'(last_acc - e1 >= 11), 1);
        drain();

        // Reset on the edge that would complete iteration 5 of f = 0x80.
        issue(8'h80, e0);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("rst_mid_divide");
        issue(8'h80, e0);
        drain();

        // Reset while a result is stalled in DONE.
        out_ready = 1'b0;
        issue(8'hFF, e0);
        wait_valid();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        check_reset_state("rst_in_done");
        step();
        check("no_valid_after_rst_in_done", int'(out_valid), 0);

        // Back-to-back stream: accepts are 11 cycles apart.
        issue(8'hFF, e0);
        issue(8'h01, e1);
        issue(8'h80, e2);
        check("b2b_gap_0", e1 - e0, 11);
        check("b2b_gap_1", e2 - e1, 11);
        drain();

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
